// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word and streams it LSB first.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    assign load_ready = (state_q == IDLE) && !rst;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        // done is a one-enabled-cycle pulse, so it only changes on enabled edges
        if (en) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_d = d;
                        cnt_d   = '0;
                        state_d = SHIFT;
`ifdef PISO_PARITY_EN
                        par_d   = ^d;
`endif
                    end
                end
                SHIFT: begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        case (state_q)
            SHIFT: begin
                sout       = shift_q[0];
                sout_valid = 1'b1;
                busy       = 1'b1;
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                sout       = par_q;
                sout_valid = 1'b1;
                busy       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH = 4); expectations track PISO_PARITY_EN.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst, en, load_valid;
    logic [3:0] d;
    logic       load_ready, sout, sout_valid, busy, done;

    int checks = 0;
    int errors = 0;

`ifdef PISO_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    piso_serializer #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] w);
        d          = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    // bits[i] is the i-th serial bit expected; ends sitting in the done cycle
    task automatic expect_stream(input string tag, input logic [4:0] bits);
        for (int i = 0; i < NB; i++) begin
            check({tag, "_sout"}, sout, bits[i]);
            check({tag, "_vld"}, sout_valid, 1'b1);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_rdy"}, load_ready, 1'b0);
            tick();
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_vld"}, sout_valid, 1'b0);
        check({tag, "_idle_sout"}, sout, 1'b0);
        check({tag, "_idle_rdy"}, load_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load_valid = 1'b0; d = 4'h0;

        // reset for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_sout", sout, 1'b0);
            check("rst_vld", sout_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_rdy", load_ready, 1'b0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_rdy", load_ready, 1'b1);

        // basic frame 9 -> 1,0,0,1 (parity 0)
        load(4'h9);
        expect_stream("basic9", 5'b0_1001);
        tick();
        check("basic9_done_pulse", done, 1'b0);

        // load attempt mid-frame is ignored
        load(4'h1);
        for (int i = 0; i < NB; i++) begin
            load_valid = (i == 1 || i == 2);
            d          = load_valid ? 4'hF : 4'h0;
            check("busy_ld_sout", sout, logic'((5'b1_0001 >> i) & 1));
            check("busy_ld_vld", sout_valid, 1'b1);
            tick();
        end
        load_valid = 1'b0;
        check("busy_ld_done", done, 1'b1);
        tick();
        check("busy_ld_idle", busy, 1'b0);
        check("busy_ld_nofollow", sout_valid, 1'b0);

        // stall two cycles after bit 1
        load(4'h9);
        check("stall_b0", sout, 1'b1);
        tick();
        check("stall_b1", sout, 1'b0);
        en = 1'b0;
        tick();
        check("stall_h1", sout, 1'b0);
        check("stall_h1_vld", sout_valid, 1'b1);
        tick();
        check("stall_h2", sout, 1'b0);
        check("stall_h2_busy", busy, 1'b1);
        en = 1'b1;
        tick();
        check("stall_b2", sout, 1'b0);
        tick();
        check("stall_b3", sout, 1'b1);
        tick();
`ifdef PISO_PARITY_EN
        check("stall_par", sout, 1'b0);
        check("stall_par_vld", sout_valid, 1'b1);
        tick();
`endif
        check("stall_done", done, 1'b1);
        en = 1'b0;
        tick();
        check("stall_done_hold", done, 1'b1);
        en = 1'b1;
        tick();
        check("stall_done_clr", done, 1'b0);

        // reset during bit 2, with a simultaneous load request
        load(4'h9);
        tick();
        tick();
        check("midrst_b2", sout, 1'b0);
        check("midrst_b2_vld", sout_valid, 1'b1);
        rst = 1'b1;
        load_valid = 1'b1;
        d = 4'hA;
        #1;
        check("midrst_rdy", load_ready, 1'b0);
        tick();
        rst = 1'b0;
        load_valid = 1'b0;
        check("midrst_sout", sout, 1'b0);
        check("midrst_vld", sout_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("midrst_nodone", done, 1'b0);
            check("midrst_stay_idle", busy, 1'b0);
            tick();
        end

        // parity word 7 -> 1,1,1,0 (+1), then back-to-back load of 6 in the done cycle
        load(4'h7);
        expect_stream("par7", 5'b1_0111);
        load(4'h6);
        expect_stream("b2b6", 5'b0_0110);
        tick();
        check("b2b6_done_clr", done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
